// File: rtl/mem_pkg.sv
// mem_pkg: shared size encodings, lane helpers and pipeline/response types for data_memory_pipe.
//   lane_strobe  : byte-lane write enables for a size/offset pair
//   load_extend  : right-align and sign/zero extend the addressed lanes of a word
//   misaligned   : flags half/word misalignment and the illegal size code
package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              error;
    } resp_t;

    typedef struct packed {
        logic       valid;
        logic       load;
        logic       error;
        size_e      size;
        logic       sgn;
        logic [1:0] off;
    } ctrl_t;

    function automatic logic misaligned(size_e size, logic [1:0] off);
        return (size == SIZE_ILL) || (size == SIZE_HALF && off[0]) || (size == SIZE_WORD && off != 2'b00);
    endfunction

    function automatic logic [3:0] lane_strobe(size_e size, logic [1:0] off);
        return size == SIZE_BYTE ? 4'b0001 << off :
               size == SIZE_HALF ? (off[1] ? 4'b1100 : 4'b0011) :
               size == SIZE_WORD ? 4'b1111 : 4'b0000;
    endfunction

    function automatic logic [WORD_W-1:0] load_extend(logic [WORD_W-1:0] word, size_e size, logic sgn, logic [1:0] off);
        logic [WORD_W-1:0] s;
        s = word >> {off, 3'b000};
        return size == SIZE_BYTE ? {{24{sgn & s[7]}}, s[7:0]} :
               size == SIZE_HALF ? {{16{sgn & s[15]}}, s[15:0]} : word;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: synchronous FIFO with a registered head (no fall-through), async active-low reset.
//   clk, rst_n : clock and asynchronous active-low reset
//   push, din  : write an entry into the backing store
//   pop        : consume the head entry when empty is low
//   dout       : registered head entry; full/empty reflect total occupancy including the head
module resp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             head_vld_q, head_vld_d;
    logic             refill;

    // The head register reloads from the store whenever it is empty or being popped,
    // so a pushed entry becomes visible one edge after the push.
    always_comb begin
        refill     = (!head_vld_q || pop) && cnt_q != '0;
        head_d     = refill ? mem[rd_q] : head_q;
        head_vld_d = refill || (head_vld_q && !pop);
        rd_d       = refill ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
        wr_d       = push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
        cnt_d      = cnt_q + CW'(push) - CW'(refill);
        full       = cnt_q + CW'(head_vld_q) == CW'(DEPTH);
        empty      = !head_vld_q;
        dout       = head_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_q] <= din;
    end

endmodule

// File: rtl/data_memory_pipe.sv
// data_memory_pipe: pipelined byte-addressed data memory with sized loads/stores and credit-limited responses.
//   Clock, Reset_n                        : clock, asynchronous active-low reset
//   ReqValid/ReqReady                     : request handshake
//   ReqWrite, ReqSize, ReqSigned, Address : request kind, access size, load extension, byte address
//   WriteData                             : right-aligned store data
//   RespValid/RespReady                   : response handshake
//   ReadData, Error                       : extended load data (0 for stores/errors), misaligned/illegal flag
module data_memory_pipe
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [1:0]            ReqSize,
    input  logic                  ReqSigned,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  RespValid,
    input  logic                  RespReady,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Error
);

    localparam int C     = READ_LATENCY + 1;
    localparam int NSTG  = READ_LATENCY - 1;
    localparam int CW    = $clog2(C + 1);
    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

    logic [DATA_WIDTH-1:0] mem [WORDS];
    ctrl_t                 stg_q [NSTG];
    ctrl_t                 stg_d [NSTG];
    logic [DATA_WIDTH-1:0] dat_q [NSTG];
    logic [DATA_WIDTH-1:0] dat_d [NSTG];
    logic [CW-1:0]         credits_q, credits_d;
    logic                  accept, pop, push_valid, fifo_full, fifo_empty;
    logic [ADDR_WIDTH-3:0] idx;
    logic [1:0]            off;
    size_e                 size;
    logic [3:0]            strb;
    logic [DATA_WIDTH-1:0] wdata_al;
    ctrl_t                 last;
    resp_t                 push_resp, head;

    always_comb begin
        size      = size_e'(ReqSize);
        idx       = Address[ADDR_WIDTH-1:2];
        off       = Address[1:0];
        strb      = misaligned(size, off) ? 4'b0000 : lane_strobe(size, off);
        wdata_al  = WriteData << {off, 3'b000};
        RespValid = !fifo_empty;
        pop       = RespValid && RespReady;
        // A pop on this edge frees a credit, so a full counter can still accept.
        ReqReady  = Reset_n && (credits_q < CW'(C) || pop);
        accept    = ReqValid && ReqReady;
        credits_d = credits_q + CW'(accept) - CW'(pop);
        stg_d[0]  = '{accept, !ReqWrite, misaligned(size, off), size, ReqSigned, off};
        dat_d[0]  = mem[idx];
        for (int i = 1; i < NSTG; i++) begin
            stg_d[i] = stg_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        last            = stg_q[NSTG-1];
        push_valid      = last.valid;
        push_resp.error = last.error;
        push_resp.data  = last.load && !last.error ? load_extend(dat_q[NSTG-1], last.size, last.sgn, last.off) : '0;
        ReadData        = head.data;
        Error           = head.error;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            credits_q <= '0;
            for (int i = 0; i < NSTG; i++) begin
                stg_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            credits_q <= credits_d;
            stg_q     <= stg_d;
            dat_q     <= dat_d;
        end
    end

    // Storage is deliberately not reset; stores commit on the accept edge.
    always_ff @(posedge Clock) begin
        if (accept && ReqWrite)
            for (int b = 0; b < 4; b++)
                if (strb[b])
                    mem[idx][8*b +: 8] <= wdata_al[8*b +: 8];
    end

    // Credits bound occupancy, so the full guard only protects the store from a logic fault.
    resp_fifo #(.DEPTH(C), .WIDTH($bits(resp_t))) u_fifo (
        .clk   (Clock),
        .rst_n (Reset_n),
        .push  (push_valid && !fifo_full),
        .din   (push_resp),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe: directed self-checking bench for data_memory_pipe at READ_LATENCY=2.
module tb_data_memory_pipe;

    localparam int RL = 2;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        ReqValid = 1'b0, ReqWrite = 1'b0, ReqSigned = 1'b0, RespReady = 1'b0;
    logic [1:0]  ReqSize = 2'b00;
    logic [7:0]  Address = 8'h00;
    logic [31:0] WriteData = 32'h0;
    logic        ReqReady, RespValid, Error;
    logic [31:0] ReadData;
    int          checks = 0, errors = 0;
    logic [32:0] got [$];

    always #5 Clock = ~Clock;

    data_memory_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(RL)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqWrite  (ReqWrite),
        .ReqSize   (ReqSize),
        .ReqSigned (ReqSigned),
        .Address   (Address),
        .WriteData (WriteData),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .ReadData  (ReadData),
        .Error     (Error)
    );

    always @(negedge Clock) if (RespValid && RespReady) got.push_back({ReadData, Error});

    always @(posedge Clock) begin
        if (Reset_n && dut.push_valid && dut.fifo_full) begin
            errors++;
            $display("FAIL fifo_overflow push while full");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [7:0] a,
                          input logic [31:0] wd, output logic [31:0] d, output logic e, output int lat);
        @(posedge Clock); #1;
        ReqValid = 1; ReqWrite = w; ReqSize = sz; ReqSigned = sg; Address = a; WriteData = wd; RespReady = 1;
        @(negedge Clock);
        lat = ReqReady ? 0 : 99;
        @(posedge Clock); #1;
        ReqValid = 0;
        @(negedge Clock);
        while (!RespValid && lat < 10) begin
            @(negedge Clock);
            lat++;
        end
        d = ReadData;
        e = Error;
    endtask

    task automatic test_reset;
        Reset_n = 1; #1 Reset_n = 0;
        #11;
        checks++; if (ReqReady !== 1'b0) begin errors++; $display("FAIL rst_req_ready got=%b exp=0", ReqReady); end
        checks++; if (RespValid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%b exp=0", RespValid); end
        checks++; if (Error !== 1'b0) begin errors++; $display("FAIL rst_error got=%b exp=0", Error); end
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL rst_read_data got=%h exp=0", ReadData); end
        @(posedge Clock); #1 Reset_n = 1;
        #1;
        checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", ReqReady); end
    endtask

    task automatic test_word;
        logic [31:0] d; logic e; int lat;
        do_req(1, 2'b10, 0, 8'h10, 32'hDEADBEEF, d, e, lat);
        checks++; if ({d, e} !== 33'h0) begin errors++; $display("FAIL st_word_resp got=%h/%b exp=0/0", d, e); end
        checks++; if (lat !== RL) begin errors++; $display("FAIL st_word_latency got=%0d exp=%0d", lat, RL); end
        do_req(0, 2'b10, 0, 8'h10, 32'h0, d, e, lat);
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_word_data got=%h exp=deadbeef", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL ld_word_error got=%b exp=0", e); end
        checks++; if (lat !== RL) begin errors++; $display("FAIL ld_word_latency got=%0d exp=%0d", lat, RL); end
    endtask

    task automatic test_byte;
        logic [31:0] d; logic e; int lat;
        do_req(1, 2'b00, 0, 8'h11, 32'h00000080, d, e, lat);
        do_req(0, 2'b00, 1, 8'h11, 32'h0, d, e, lat);
        checks++; if ({d, e} !== {32'hFFFFFF80, 1'b0}) begin errors++; $display("FAIL ld_byte_signed got=%h/%b exp=ffffff80/0", d, e); end
        do_req(0, 2'b00, 0, 8'h11, 32'h0, d, e, lat);
        checks++; if ({d, e} !== {32'h00000080, 1'b0}) begin errors++; $display("FAIL ld_byte_unsigned got=%h/%b exp=00000080/0", d, e); end
        do_req(0, 2'b10, 1, 8'h10, 32'h0, d, e, lat);
        checks++; if ({d, e} !== {32'hDEAD80EF, 1'b0}) begin errors++; $display("FAIL ld_word_after_byte got=%h/%b exp=dead80ef/0", d, e); end
        do_req(0, 2'b01, 1, 8'h12, 32'h0, d, e, lat);
        checks++; if ({d, e} !== {32'hFFFFDEAD, 1'b0}) begin errors++; $display("FAIL ld_half_signed got=%h/%b exp=ffffdead/0", d, e); end
        do_req(0, 2'b01, 0, 8'h10, 32'h0, d, e, lat);
        checks++; if ({d, e} !== {32'h000080EF, 1'b0}) begin errors++; $display("FAIL ld_half_unsigned got=%h/%b exp=000080ef/0", d, e); end
    endtask

    task automatic test_misaligned;
        logic [31:0] d; logic e; int lat;
        do_req(1, 2'b01, 0, 8'h13, 32'h00001234, d, e, lat);
        checks++; if ({d, e} !== {32'h0, 1'b1}) begin errors++; $display("FAIL st_half_misaligned got=%h/%b exp=0/1", d, e); end
        do_req(0, 2'b10, 0, 8'h10, 32'h0, d, e, lat);
        checks++; if ({d, e} !== {32'hDEAD80EF, 1'b0}) begin errors++; $display("FAIL mem_unchanged got=%h/%b exp=dead80ef/0", d, e); end
        do_req(0, 2'b11, 0, 8'h10, 32'h0, d, e, lat);
        checks++; if ({d, e} !== {32'h0, 1'b1}) begin errors++; $display("FAIL size_illegal got=%h/%b exp=0/1", d, e); end
        do_req(0, 2'b10, 0, 8'h12, 32'h0, d, e, lat);
        checks++; if ({d, e} !== {32'h0, 1'b1}) begin errors++; $display("FAIL ld_word_misaligned got=%h/%b exp=0/1", d, e); end
    endtask

    task automatic test_backpressure;
        logic [31:0] d; logic e; int lat, acc; logic take;
        do_req(1, 2'b10, 0, 8'h14, 32'h11111111, d, e, lat);
        do_req(1, 2'b10, 0, 8'h18, 32'h22222222, d, e, lat);
        @(posedge Clock); #1;
        got.delete();
        RespReady = 0; ReqValid = 1; ReqWrite = 0; ReqSize = 2'b10; ReqSigned = 0; Address = 8'h10;
        acc = 0;
        repeat (8) begin
            @(negedge Clock);
            take = ReqReady;
            @(posedge Clock); #1;
            if (take) begin acc++; Address = Address + 8'd4; end
        end
        @(negedge Clock);
        checks++; if (acc !== RL + 1) begin errors++; $display("FAIL bp_accepts got=%0d exp=%0d", acc, RL + 1); end
        checks++; if (ReqReady !== 1'b0) begin errors++; $display("FAIL bp_ready_low got=%b exp=0", ReqReady); end
        checks++; if ({RespValid, ReadData} !== {1'b1, 32'hDEAD80EF}) begin errors++; $display("FAIL bp_head_stable got=%b/%h exp=1/dead80ef", RespValid, ReadData); end
        @(posedge Clock); #1;
        ReqValid = 0; RespReady = 1;
        repeat (10) @(negedge Clock);
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL bp_resp_count got=%0d exp=3", got.size()); end
        if (got.size() == 3) begin
            checks++; if (got[0] !== {32'hDEAD80EF, 1'b0}) begin errors++; $display("FAIL bp_resp0 got=%h exp=dead80ef/0", got[0]); end
            checks++; if (got[1] !== {32'h11111111, 1'b0}) begin errors++; $display("FAIL bp_resp1 got=%h exp=11111111/0", got[1]); end
            checks++; if (got[2] !== {32'h22222222, 1'b0}) begin errors++; $display("FAIL bp_resp2 got=%h exp=22222222/0", got[2]); end
        end
        checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL bp_ready_restored got=%b exp=1", ReqReady); end
    endtask

    task automatic test_back_to_back;
        int stall, bad;
        @(posedge Clock); #1;
        got.delete();
        RespReady = 1; ReqValid = 1; ReqWrite = 1; ReqSize = 2'b10; Address = 8'h20; WriteData = 32'hCAFEF00D;
        stall = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if (!ReqReady) stall++;
            @(posedge Clock); #1;
            ReqWrite = 0;
        end
        ReqValid = 0;
        repeat (8) @(negedge Clock);
        checks++; if (stall !== 0) begin errors++; $display("FAIL b2b_ready_drop got=%0d exp=0", stall); end
        checks++; if (got.size() !== 10) begin errors++; $display("FAIL b2b_resp_count got=%0d exp=10", got.size()); end
        if (got.size() == 10) begin
            checks++; if (got[0] !== 33'h0) begin errors++; $display("FAIL b2b_store_resp got=%h exp=0", got[0]); end
            bad = 0;
            for (int i = 1; i < 10; i++) if (got[i] !== {32'hCAFEF00D, 1'b0}) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_load_data got=%h bad=%0d exp=cafef00d/0", got[1], bad); end
        end
    endtask

    task automatic test_reset_inflight;
        logic [31:0] d; logic e; int lat;
        @(posedge Clock); #1;
        RespReady = 1; ReqValid = 1; ReqWrite = 0; ReqSize = 2'b10; Address = 8'h20;
        @(posedge Clock); #1 Address = 8'h10;
        @(posedge Clock); #1;
        ReqValid = 0; Reset_n = 0;
        #2;
        checks++; if ({RespValid, ReqReady, Error, ReadData} !== 35'h0) begin errors++; $display("FAIL rif_outputs got=%b%b%b/%h exp=000/0", RespValid, ReqReady, Error, ReadData); end
        @(posedge Clock); @(posedge Clock); #1;
        got.delete();
        Reset_n = 1;
        repeat (6) @(negedge Clock);
        checks++; if (got.size() !== 0 || RespValid !== 1'b0) begin errors++; $display("FAIL rif_stale got=%0d/%b exp=0/0", got.size(), RespValid); end
        do_req(0, 2'b10, 0, 8'h20, 32'h0, d, e, lat);
        checks++; if ({d, e} !== {32'hCAFEF00D, 1'b0}) begin errors++; $display("FAIL rif_mem_kept got=%h/%b exp=cafef00d/0", d, e); end
        checks++; if (lat !== RL) begin errors++; $display("FAIL rif_latency got=%0d exp=%0d", lat, RL); end
        do_req(0, 2'b10, 0, 8'h10, 32'h0, d, e, lat);
        checks++; if ({d, e} !== {32'hDEAD80EF, 1'b0}) begin errors++; $display("FAIL rif_mem_kept2 got=%h/%b exp=dead80ef/0", d, e); end
    endtask

    initial begin
        test_reset;
        test_word;
        test_byte;
        test_misaligned;
        test_backpressure;
        test_back_to_back;
        test_reset_inflight;
        @(posedge Clock); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
